snoopy_invalidate_controller: RTL and testbench



---
 rtl/snoopy_invalidate_controller_if.sv | 28 ++
 rtl/snoopy_invalidate_controller.sv | 153 +++++++++++++++
 tb/tb_snoopy_invalidate_controller.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoopy_invalidate_controller_if.sv
// Tag/state/data array port of one cache unit, shared by its snoop controller.
interface SnoopyCacheInterface #(
    parameter int unsigned TAG_WIDTH         = 6,
    parameter int unsigned INDEX_WIDTH       = 6,
    parameter int unsigned OFFSET_WIDTH      = 4,
    parameter int unsigned SET_ASSOCIATIVITY = 2,
    parameter int unsigned DATA_WIDTH        = 16
) ();
    logic [INDEX_WIDTH-1:0]       index;
    logic [OFFSET_WIDTH-1:0]      offset;
    logic [TAG_WIDTH-1:0]         tagIn;
    logic [1:0]                   stateIn;
    logic                         writeState;
    logic [DATA_WIDTH-1:0]        dataOut;
    logic [SET_ASSOCIATIVITY-1:0] cacheNumber;
    logic [1:0]                   stateOut;
    logic                         hit;

    modport controller (
        output index, offset, tagIn, stateIn, writeState,
        input  dataOut, cacheNumber, stateOut, hit
    );

    modport cache (
        input  index, offset, tagIn, stateIn, writeState,
        output dataOut, cacheNumber, stateOut, hit
    );
endinterface

// File: rtl/snoopy_invalidate_controller.sv
// Snoop-side MSI controller: looks up a snooped block, flushes it if modified,
// downgrades/invalidates its state and acknowledges the bus request.
module snoopy_invalidate_controller #(
    parameter int unsigned TAG_WIDTH         = 6,
    parameter int unsigned INDEX_WIDTH       = 6,
    parameter int unsigned OFFSET_WIDTH      = 4,
    parameter int unsigned SET_ASSOCIATIVITY = 2,
    parameter int unsigned DATA_WIDTH        = 16,
    parameter logic [1:0]  INVALID_STATE     = 2'b00,
    parameter logic [1:0]  SHARED_STATE      = 2'b01,
    parameter logic [1:0]  MODIFIED_STATE    = 2'b10
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        snoopRequest,
    input  logic [1:0]                                  snoopCommand,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] snoopAddress,
    output logic                                        snoopAck,
    output logic                                        snoopShared,
    output logic [DATA_WIDTH-1:0]                       flushData,
    output logic                                        flushValid,
    input  logic                                        flushReady,
    SnoopyCacheInterface.controller                     cacheInterface
);
    localparam int unsigned ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_FLUSH, ST_UPDATE, ST_RESPOND
    } state_e;

    typedef enum logic [1:0] {
        CMD_READ       = 2'b00,
        CMD_READ_EX    = 2'b01,
        CMD_INVALIDATE = 2'b10,
        CMD_RESERVED   = 2'b11
    } cmd_e;

    state_e                  state_q, state_d;
    cmd_e                    cmd_q, cmd_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [INDEX_WIDTH-1:0]  index_q, index_d;
    logic                    valid_q, valid_d;
    logic [1:0]              line_state_q, line_state_d;
    logic [OFFSET_WIDTH-1:0] word_q, word_d;

    logic                    line_valid;
    logic [1:0]              target_state;
    logic [OFFSET_WIDTH-1:0] unused_offset;
    logic [SET_ASSOCIATIVITY-1:0] unused_way;

    // Block offset of the snooped address and the hit way play no part in the protocol.
    assign unused_offset = snoopAddress[OFFSET_WIDTH-1:0];
    assign unused_way    = cacheInterface.cacheNumber;

    assign line_valid = cacheInterface.hit && (cacheInterface.stateOut != INVALID_STATE);

    // UPDATE is only reached for valid lines; only a read of a modified line keeps a copy.
    assign target_state = (line_state_q == MODIFIED_STATE && cmd_q == CMD_READ)
                          ? SHARED_STATE : INVALID_STATE;

    // State and captured-request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= CMD_READ;
            tag_q        <= '0;
            index_q      <= '0;
            valid_q      <= 1'b0;
            line_state_q <= '0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            valid_q      <= valid_d;
            line_state_q <= line_state_d;
            word_q       <= word_d;
        end
    end

    // Next-state decode and per-state drive of bus and cache-array outputs.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        tag_d        = tag_q;
        index_d      = index_q;
        valid_d      = valid_q;
        line_state_d = line_state_q;
        word_d       = word_q;

        snoopAck                  = 1'b0;
        snoopShared               = 1'b0;
        flushData                 = '0;
        flushValid                = 1'b0;
        cacheInterface.index      = '0;
        cacheInterface.offset     = '0;
        cacheInterface.tagIn      = '0;
        cacheInterface.stateIn    = '0;
        cacheInterface.writeState = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (snoopRequest) begin
                    cmd_d   = cmd_e'(snoopCommand);
                    tag_d   = snoopAddress[ADDR_WIDTH-1 -: TAG_WIDTH];
                    index_d = snoopAddress[OFFSET_WIDTH +: INDEX_WIDTH];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                cacheInterface.index = index_q;
                cacheInterface.tagIn = tag_q;
                valid_d      = line_valid;
                line_state_d = cacheInterface.stateOut;
                word_d       = '0;
                if (!line_valid || cmd_q == CMD_RESERVED)
                    state_d = ST_RESPOND;
                else if (cacheInterface.stateOut == MODIFIED_STATE)
                    state_d = ST_FLUSH;
                else if (cmd_q == CMD_READ)
                    state_d = ST_RESPOND;
                else
                    state_d = ST_UPDATE;
            end
            ST_FLUSH: begin
                cacheInterface.index  = index_q;
                cacheInterface.tagIn  = tag_q;
                cacheInterface.offset = word_q;
                flushData  = cacheInterface.dataOut;
                flushValid = 1'b1;
                if (flushReady) begin
                    word_d = word_q + {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};
                    if (word_q == '1)
                        state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                cacheInterface.index      = index_q;
                cacheInterface.tagIn      = tag_q;
                cacheInterface.stateIn    = target_state;
                cacheInterface.writeState = 1'b1;
                state_d = ST_RESPOND;
            end
            ST_RESPOND: begin
                snoopAck    = 1'b1;
                snoopShared = valid_q && (cmd_q == CMD_READ);
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_snoopy_invalidate_controller.sv
// Directed bench for snoopy_invalidate_controller with a small single-way cache model.
module tb_snoopy_invalidate_controller;
    logic        clock;
    logic        reset;
    logic        snoopRequest;
    logic [1:0]  snoopCommand;
    logic [15:0] snoopAddress;
    logic        snoopAck;
    logic        snoopShared;
    logic [15:0] flushData;
    logic        flushValid;
    logic        flushReady;

    SnoopyCacheInterface #(
        .TAG_WIDTH(6), .INDEX_WIDTH(6), .OFFSET_WIDTH(4),
        .SET_ASSOCIATIVITY(2), .DATA_WIDTH(16)
    ) cif ();

    snoopy_invalidate_controller #(
        .TAG_WIDTH(6), .INDEX_WIDTH(6), .OFFSET_WIDTH(4),
        .SET_ASSOCIATIVITY(2), .DATA_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset),
        .snoopRequest(snoopRequest), .snoopCommand(snoopCommand),
        .snoopAddress(snoopAddress), .snoopAck(snoopAck), .snoopShared(snoopShared),
        .flushData(flushData), .flushValid(flushValid), .flushReady(flushReady),
        .cacheInterface(cif.controller)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cache model: one way per index, word w of a line holds base + w.
    logic [5:0]  tag_mem  [64];
    logic [1:0]  st_mem   [64];
    logic [15:0] base_mem [64];
    logic        ld_en;
    logic [5:0]  ld_idx, ld_tag;
    logic [1:0]  ld_st;
    logic [15:0] ld_base;

    assign cif.hit         = (tag_mem[cif.index] == cif.tagIn);
    assign cif.stateOut    = st_mem[cif.index];
    assign cif.dataOut     = base_mem[cif.index] + 16'(cif.offset);
    assign cif.cacheNumber = '0;

    // Model array writes: bench preloads, or the controller's state write.
    always @(posedge clock) begin
        if (ld_en) begin
            tag_mem[ld_idx]  <= ld_tag;
            st_mem[ld_idx]   <= ld_st;
            base_mem[ld_idx] <= ld_base;
        end else if (cif.writeState) begin
            st_mem[cif.index] <= cif.stateIn;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    int          r_lat, r_wr_cnt, r_fl_cycles, r_fl_words, r_fl_bad;
    logic        r_shared, r_ack_after;
    logic [1:0]  r_wr_st;
    bit          r_wr_loc_ok;

    task automatic load_line(input logic [5:0] idx, input logic [5:0] tag,
                             input logic [1:0] st, input logic [15:0] base);
        @(negedge clock);
        ld_en = 1'b1; ld_idx = idx; ld_tag = tag; ld_st = st; ld_base = base;
        @(posedge clock); #1;
        ld_en = 1'b0;
    endtask

    // Issues one snoop and records what the controller did until its ack.
    task automatic run_txn(input logic [1:0] cmd, input logic [5:0] tag, input logic [5:0] idx,
                           input logic [15:0] base, input int stall_word, input int stall_len,
                           input bit drop_req);
        int cyc, word, stalls;
        bit done;
        r_lat = -1; r_shared = 1'b0; r_wr_cnt = 0; r_wr_st = 2'b11; r_wr_loc_ok = 1'b1;
        r_fl_cycles = 0; r_fl_bad = 0; r_ack_after = 1'b1;
        cyc = 0; word = 0; stalls = 0; done = 1'b0;
        @(negedge clock);
        snoopCommand = cmd; snoopAddress = {tag, idx, 4'h9}; snoopRequest = 1'b1; flushReady = 1'b1;
        while (!done && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
            if (drop_req && cyc == 1) snoopRequest = 1'b0;
            if (cif.writeState) begin
                r_wr_cnt++;
                r_wr_st = cif.stateIn;
                if (cif.index !== idx || cif.tagIn !== tag) r_wr_loc_ok = 1'b0;
            end
            if (flushValid) begin
                r_fl_cycles++;
                if (flushData !== base + 16'(word)) r_fl_bad++;
                if (word == stall_word && stalls < stall_len) begin
                    flushReady = 1'b0; stalls++;
                end else begin
                    flushReady = 1'b1; word++;
                end
            end
            if (snoopAck) begin
                r_lat = cyc; r_shared = snoopShared; done = 1'b1; snoopRequest = 1'b0;
            end
        end
        r_fl_words = word;
        snoopRequest = 1'b0; flushReady = 1'b1;
        @(posedge clock); #1;
        r_ack_after = snoopAck;
    endtask

    task automatic test_reset();
        @(negedge clock);
        vectors++;
        if ({snoopAck, snoopShared, flushValid, cif.writeState, flushData, cif.index,
             cif.offset, cif.tagIn, cif.stateIn} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", {snoopAck, snoopShared, flushValid,
                     cif.writeState, flushData, cif.index, cif.offset, cif.tagIn, cif.stateIn});
        end
        reset = 1'b1;
        @(posedge clock); #1;
        vectors++;
        if ({snoopAck, flushValid, cif.writeState} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b expected 000", {snoopAck, flushValid, cif.writeState});
        end
    endtask

    task automatic test_miss();
        run_txn(2'b00, 6'h05, 6'h03, 16'h0, -1, 0, 1'b0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL miss_latency: got %0d expected 2", r_lat); end
        vectors++; if (r_shared !== 1'b0) begin miscompares++; $display("FAIL miss_shared: got %b expected 0", r_shared); end
        vectors++; if (r_wr_cnt !== 0) begin miscompares++; $display("FAIL miss_writes: got %0d expected 0", r_wr_cnt); end
        vectors++; if (r_fl_cycles !== 0) begin miscompares++; $display("FAIL miss_flush: got %0d expected 0", r_fl_cycles); end
        vectors++; if (r_ack_after !== 1'b0) begin miscompares++; $display("FAIL miss_ack_pulse: got %b expected 0", r_ack_after); end
        // Tag matches but the line is INVALID: still a miss.
        run_txn(2'b00, 6'h14, 6'h0D, 16'h0, -1, 0, 1'b0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL invalid_hit_latency: got %0d expected 2", r_lat); end
        vectors++; if (r_shared !== 1'b0) begin miscompares++; $display("FAIL invalid_hit_shared: got %b expected 0", r_shared); end
    endtask

    task automatic test_shared_read();
        run_txn(2'b00, 6'h11, 6'h08, 16'h0, -1, 0, 1'b0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL shrd_latency: got %0d expected 2", r_lat); end
        vectors++; if (r_shared !== 1'b1) begin miscompares++; $display("FAIL shrd_shared: got %b expected 1", r_shared); end
        vectors++; if (r_wr_cnt !== 0) begin miscompares++; $display("FAIL shrd_writes: got %0d expected 0", r_wr_cnt); end
        vectors++; if (st_mem[8] !== 2'b01) begin miscompares++; $display("FAIL shrd_state: got %b expected 01", st_mem[8]); end
    endtask

    task automatic test_shared_invalidate();
        run_txn(2'b10, 6'h12, 6'h09, 16'h0, -1, 0, 1'b1);
        vectors++; if (r_lat !== 3) begin miscompares++; $display("FAIL inv_latency: got %0d expected 3", r_lat); end
        vectors++; if (r_wr_cnt !== 1) begin miscompares++; $display("FAIL inv_writes: got %0d expected 1", r_wr_cnt); end
        vectors++; if (r_wr_st !== 2'b00) begin miscompares++; $display("FAIL inv_statein: got %b expected 00", r_wr_st); end
        vectors++; if (r_wr_loc_ok !== 1'b1) begin miscompares++; $display("FAIL inv_write_loc: got %b expected 1", r_wr_loc_ok); end
        vectors++; if (r_shared !== 1'b0) begin miscompares++; $display("FAIL inv_shared: got %b expected 0", r_shared); end
        vectors++; if (st_mem[9] !== 2'b00) begin miscompares++; $display("FAIL inv_state: got %b expected 00", st_mem[9]); end
    endtask

    task automatic test_modified_read();
        run_txn(2'b00, 6'h21, 6'h0A, 16'h1000, -1, 0, 1'b0);
        vectors++; if (r_lat !== 19) begin miscompares++; $display("FAIL modrd_latency: got %0d expected 19", r_lat); end
        vectors++; if (r_fl_cycles !== 16) begin miscompares++; $display("FAIL modrd_flush_cycles: got %0d expected 16", r_fl_cycles); end
        vectors++; if (r_fl_words !== 16) begin miscompares++; $display("FAIL modrd_flush_words: got %0d expected 16", r_fl_words); end
        vectors++; if (r_fl_bad !== 0) begin miscompares++; $display("FAIL modrd_flush_data: got %0d bad expected 0", r_fl_bad); end
        vectors++; if (r_wr_cnt !== 1) begin miscompares++; $display("FAIL modrd_writes: got %0d expected 1", r_wr_cnt); end
        vectors++; if (r_wr_st !== 2'b01) begin miscompares++; $display("FAIL modrd_statein: got %b expected 01", r_wr_st); end
        vectors++; if (r_shared !== 1'b1) begin miscompares++; $display("FAIL modrd_shared: got %b expected 1", r_shared); end
        vectors++; if (st_mem[10] !== 2'b01) begin miscompares++; $display("FAIL modrd_state: got %b expected 01", st_mem[10]); end
    endtask

    task automatic test_modified_stall();
        run_txn(2'b01, 6'h22, 6'h0B, 16'h1000, 5, 3, 1'b0);
        vectors++; if (r_lat !== 22) begin miscompares++; $display("FAIL stall_latency: got %0d expected 22", r_lat); end
        vectors++; if (r_fl_cycles !== 19) begin miscompares++; $display("FAIL stall_flush_cycles: got %0d expected 19", r_fl_cycles); end
        vectors++; if (r_fl_bad !== 0) begin miscompares++; $display("FAIL stall_flush_data: got %0d bad expected 0", r_fl_bad); end
        vectors++; if (r_wr_st !== 2'b00) begin miscompares++; $display("FAIL stall_statein: got %b expected 00", r_wr_st); end
        vectors++; if (r_shared !== 1'b0) begin miscompares++; $display("FAIL stall_shared: got %b expected 0", r_shared); end
        vectors++; if (st_mem[11] !== 2'b00) begin miscompares++; $display("FAIL stall_state: got %b expected 00", st_mem[11]); end
    endtask

    task automatic test_reserved();
        run_txn(2'b11, 6'h13, 6'h0C, 16'h0, -1, 0, 1'b0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL rsvd_latency: got %0d expected 2", r_lat); end
        vectors++; if (r_shared !== 1'b0) begin miscompares++; $display("FAIL rsvd_shared: got %b expected 0", r_shared); end
        vectors++; if (st_mem[12] !== 2'b01) begin miscompares++; $display("FAIL rsvd_state: got %b expected 01", st_mem[12]); end
    endtask

    task automatic test_back_to_back();
        run_txn(2'b00, 6'h11, 6'h08, 16'h0, -1, 0, 1'b0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 2", r_lat); end
        run_txn(2'b00, 6'h05, 6'h03, 16'h0, -1, 0, 1'b0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 2", r_lat); end
        vectors++; if (r_shared !== 1'b0) begin miscompares++; $display("FAIL b2b_second_shared: got %b expected 0", r_shared); end
    endtask

    task automatic test_reset_mid_flush();
        int  cyc, word;
        bit  found;
        logic seen;
        cyc = 0; word = 0; found = 1'b0; seen = 1'b0;
        @(negedge clock);
        snoopCommand = 2'b00; snoopAddress = {6'h23, 6'h0E, 4'h0}; snoopRequest = 1'b1; flushReady = 1'b1;
        while (!found && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            if (flushValid) begin
                if (word == 7) found = 1'b1;
                else word++;
            end
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL rst_reach_word7: got %b expected 1", found); end
        vectors++; if (flushData !== 16'h2007) begin miscompares++; $display("FAIL rst_word7_data: got %h expected 2007", flushData); end
        #2;
        reset = 1'b0; snoopRequest = 1'b0;
        #1;
        vectors++;
        if ({snoopAck, snoopShared, flushValid, cif.writeState, flushData, cif.index,
             cif.offset, cif.tagIn, cif.stateIn} !== 38'd0) begin
            miscompares++;
            $display("FAIL rst_async_outputs: got %h expected 0", {snoopAck, snoopShared, flushValid,
                     cif.writeState, flushData, cif.index, cif.offset, cif.tagIn, cif.stateIn});
        end
        repeat (2) begin
            @(posedge clock); #1;
            seen = seen | cif.writeState | snoopAck;
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            seen = seen | cif.writeState | snoopAck;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_no_write: got %b expected 0", seen); end
        vectors++; if (st_mem[14] !== 2'b10) begin miscompares++; $display("FAIL rst_state_kept: got %b expected 10", st_mem[14]); end
        run_txn(2'b00, 6'h05, 6'h03, 16'h0, -1, 0, 1'b0);
        vectors++; if (r_lat !== 2) begin miscompares++; $display("FAIL rst_then_miss_latency: got %0d expected 2", r_lat); end
        vectors++; if (r_shared !== 1'b0) begin miscompares++; $display("FAIL rst_then_miss_shared: got %b expected 0", r_shared); end
    endtask

    initial begin
        reset = 1'b0; snoopRequest = 1'b0; snoopCommand = 2'b00; snoopAddress = '0;
        flushReady = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_tag = '0; ld_st = '0; ld_base = '0;
        load_line(6'h03, 6'h2A, 2'b01, 16'h0300);
        load_line(6'h08, 6'h11, 2'b01, 16'h0800);
        load_line(6'h09, 6'h12, 2'b01, 16'h0900);
        load_line(6'h0A, 6'h21, 2'b10, 16'h1000);
        load_line(6'h0B, 6'h22, 2'b10, 16'h1000);
        load_line(6'h0C, 6'h13, 2'b01, 16'h0C00);
        load_line(6'h0D, 6'h14, 2'b00, 16'h0D00);
        load_line(6'h0E, 6'h23, 2'b10, 16'h2000);
        test_reset();
        test_miss();
        test_shared_read();
        test_shared_invalidate();
        test_modified_read();
        test_modified_stall();
        test_reserved();
        test_back_to_back();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
